// File: rtl/dog_scale_aligner.sv
// -----------------------------------------------------------------------------
// dog_scale_aligner
//
// Purpose:
//   Re-aligns NUM_SCALES Gaussian scale streams of one octave, each of which
//   arrives with its own strobe and its own pipeline delay. Every scale is
//   written into its own FIFO. Once every FIFO holds at least one sample, all
//   FIFOs pop together, and NUM_SCALES-1 Difference-of-Gaussian pixels are
//   produced from the popped words. Each difference is rectified (clipped or
//   absolute value), shifted left and saturated. Sticky error flags report
//   FIFO overflow and blanking tags that disagree across scales.
//
// Ports:
//   clock         system clock
//   reset         synchronous, active-high; flushes FIFOs, clears outputs
//   din           scale k in bits [k*DATA_WIDTH +: DATA_WIDTH], k=0 least blurred
//   validin       per-scale sample strobe
//   blanking_in   per-scale blanking tag, sampled together with validin[k]
//   clear_err     clears the sticky overflow / misalign flags
//   dog_dout      DoG j in bits [j*DATA_WIDTH +: DATA_WIDTH]
//   dog_valid     dog_dout carries a non-blanked aligned sample
//   blanking_out  aligned sample was tagged as blanking
//   overflow      sticky per scale: a push into a full FIFO was dropped
//   misalign      sticky: the popped blanking tags disagreed
// -----------------------------------------------------------------------------
module dog_scale_aligner #(
  parameter int NUM_SCALES       = 5,
  parameter int DATA_WIDTH       = 8,
  parameter int FIFO_DEPTH       = 1024,
  parameter int DIFFERENCE_SHIFT = 0,
  parameter int ABS_MODE         = 0
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [NUM_SCALES*DATA_WIDTH-1:0]    din,
  input  logic [NUM_SCALES-1:0]               validin,
  input  logic [NUM_SCALES-1:0]               blanking_in,
  input  logic                                clear_err,
  output logic [(NUM_SCALES-1)*DATA_WIDTH-1:0] dog_dout,
  output logic                                dog_valid,
  output logic                                blanking_out,
  output logic [NUM_SCALES-1:0]               overflow,
  output logic                                misalign
);

  localparam int NUM_DOG = NUM_SCALES - 1;
  localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = DATA_WIDTH + 1;              // {blanking tag, pixel}
  localparam int SHIFT_W = DATA_WIDTH + 1 + DIFFERENCE_SHIFT;

  // Per-scale FIFO status and popped words
  logic [NUM_SCALES-1:0]            empty;
  logic [NUM_SCALES-1:0]            full;
  logic [NUM_SCALES-1:0]            push_ok;
  logic [NUM_SCALES-1:0]            push_drop;
  logic [NUM_SCALES-1:0]            pop_tag;
  logic [NUM_SCALES*DATA_WIDTH-1:0] pop_data;
  logic                             pop;

  // Rectified, shifted, saturated differences for the popped words
  logic [NUM_DOG*DATA_WIDTH-1:0]    dog_result;

  // Output stage and sticky flags
  logic [NUM_DOG*DATA_WIDTH-1:0]    dog_dout_reg;
  logic                             dog_valid_reg;
  logic                             blanking_out_reg;
  logic [NUM_SCALES-1:0]            overflow_reg;
  logic                             misalign_reg;

  logic                             any_tag;
  logic                             tag_mismatch;

  // All scales advance together, and only when every scale has a sample.
  assign pop = &(~empty);

  // ---------------------------------------------------------------------------
  // Per-scale FIFOs
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NUM_SCALES; gi++) begin : g_fifo
      logic [ENTRY_W-1:0] mem_reg [FIFO_DEPTH];
      logic [PTR_W-1:0]   wr_ptr_reg;
      logic [PTR_W-1:0]   rd_ptr_reg;
      logic [CNT_W-1:0]   count_reg;
      logic [ENTRY_W-1:0] rd_word;

      assign empty[gi] = (count_reg == '0);
      assign full[gi]  = (count_reg == CNT_W'(FIFO_DEPTH));

      // A full FIFO still accepts a push in a pop cycle: the slot being
      // vacated this cycle is reused, so the count stays at FIFO_DEPTH.
      assign push_ok[gi]   = validin[gi] && (!full[gi] || pop);
      assign push_drop[gi] = validin[gi] && full[gi] && !pop;

      always_ff @(posedge clock) begin
        if (push_ok[gi]) begin
          mem_reg[wr_ptr_reg] <= {blanking_in[gi], din[gi*DATA_WIDTH +: DATA_WIDTH]};
        end
      end

      // Pointers wrap naturally because FIFO_DEPTH is a power of two.
      always_ff @(posedge clock) begin
        if (reset) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
          count_reg  <= '0;
        end else begin
          if (push_ok[gi]) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
          end
          if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
          end
          if (push_ok[gi] && !pop) begin
            count_reg <= count_reg + CNT_W'(1);
          end else if (!push_ok[gi] && pop) begin
            count_reg <= count_reg - CNT_W'(1);
          end
        end
      end

      // Head-of-queue word is read combinationally so the popped word lands
      // in the output register at the end of the pop cycle (latency 2 from
      // an aligned push to dog_valid).
      assign rd_word = mem_reg[rd_ptr_reg];
      assign pop_tag[gi] = rd_word[DATA_WIDTH];
      assign pop_data[gi*DATA_WIDTH +: DATA_WIDTH] = rd_word[DATA_WIDTH-1:0];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Difference arithmetic: d = g[j] - g[j+1], rectify, shift, saturate
  // ---------------------------------------------------------------------------
  generate
    for (gi = 0; gi < NUM_DOG; gi++) begin : g_dog
      logic signed [DATA_WIDTH:0] diff;
      logic        [DATA_WIDTH:0] neg_diff;
      logic        [DATA_WIDTH:0] mag;
      logic        [SHIFT_W-1:0]  shifted;
      logic        [DATA_WIDTH-1:0] sat;

      assign diff = $signed({1'b0, pop_data[gi*DATA_WIDTH +: DATA_WIDTH]})
                  - $signed({1'b0, pop_data[(gi+1)*DATA_WIDTH +: DATA_WIDTH]});
      assign neg_diff = -diff;

      always_comb begin
        mag = diff;
        if (diff[DATA_WIDTH]) begin
          mag = (ABS_MODE != 0) ? neg_diff : '0;
        end
      end

      // Any bit at or above DATA_WIDTH after the shift means the result
      // does not fit and is pinned to full scale.
      assign shifted = SHIFT_W'(mag) << DIFFERENCE_SHIFT;

      always_comb begin
        sat = shifted[DATA_WIDTH-1:0];
        if (|shifted[SHIFT_W-1:DATA_WIDTH]) begin
          sat = '1;
        end
      end

      assign dog_result[gi*DATA_WIDTH +: DATA_WIDTH] = sat;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Output register and sticky error flags
  // ---------------------------------------------------------------------------
  assign any_tag      = |pop_tag;
  assign tag_mismatch = any_tag && !(&pop_tag);

  always_ff @(posedge clock) begin
    if (reset) begin
      dog_dout_reg     <= '0;
      dog_valid_reg    <= 1'b0;
      blanking_out_reg <= 1'b0;
      overflow_reg     <= '0;
      misalign_reg     <= 1'b0;
    end else begin
      dog_valid_reg    <= pop && !any_tag;
      blanking_out_reg <= pop && any_tag;
      dog_dout_reg     <= (pop && !any_tag) ? dog_result : '0;
      // Clear first, then OR in this cycle's events so a coincident set wins.
      overflow_reg     <= (clear_err ? '0 : overflow_reg) | push_drop;
      misalign_reg     <= (clear_err ? 1'b0 : misalign_reg) | (pop && tag_mismatch);
    end
  end

  assign dog_dout     = dog_dout_reg;
  assign dog_valid    = dog_valid_reg;
  assign blanking_out = blanking_out_reg;
  assign overflow     = overflow_reg;
  assign misalign     = misalign_reg;

endmodule

// File: tb/tb_dog_scale_aligner.sv
// -----------------------------------------------------------------------------
// tb_dog_scale_aligner
//
// Drives two instances with identical stimulus: one clipping with no shift,
// one in absolute-value mode with a shift of 2. Expected words are queued when
// stimulus is issued; a monitor pops and compares whenever a DUT presents an
// output. Aligned pushes also carry the cycle in which the output must appear.
// -----------------------------------------------------------------------------
module tb_dog_scale_aligner;

  localparam int NS    = 5;
  localparam int DW    = 8;
  localparam int DEPTH = 16;

  logic          clock = 1'b0;
  logic          reset;
  logic          clear_err;
  logic [39:0]   din;
  logic [4:0]    validin;
  logic [4:0]    blanking_in;

  logic [31:0]   dout_a, dout_b;
  logic          valid_a, valid_b;
  logic          blank_a, blank_b;
  logic [4:0]    ovf_a, ovf_b;
  logic          mis_a, mis_b;

  dog_scale_aligner #(
    .NUM_SCALES(NS), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH),
    .DIFFERENCE_SHIFT(0), .ABS_MODE(0)
  ) dut_a (
    .clock(clock), .reset(reset), .din(din), .validin(validin),
    .blanking_in(blanking_in), .clear_err(clear_err),
    .dog_dout(dout_a), .dog_valid(valid_a), .blanking_out(blank_a),
    .overflow(ovf_a), .misalign(mis_a)
  );

  dog_scale_aligner #(
    .NUM_SCALES(NS), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH),
    .DIFFERENCE_SHIFT(2), .ABS_MODE(1)
  ) dut_b (
    .clock(clock), .reset(reset), .din(din), .validin(validin),
    .blanking_in(blanking_in), .clear_err(clear_err),
    .dog_dout(dout_b), .dog_valid(valid_b), .blanking_out(blank_b),
    .overflow(ovf_b), .misalign(mis_b)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        blank;
    logic [31:0] data;
    int          at;     // expected monitor cycle, -1 when not checked
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Independent reference: integer arithmetic on each neighbouring pair.
  function automatic logic [31:0] ref_dog(input logic [39:0] g, input bit abs_m, input int sh);
    logic [31:0] res;
    res = '0;
    for (int j = 0; j < 4; j++) begin
      int a;
      int b;
      int d;
      int m;
      a = int'(g[j*8 +: 8]);
      b = int'(g[(j+1)*8 +: 8]);
      d = a - b;
      if (d < 0) m = abs_m ? -d : 0;
      else       m = d;
      m = m * (1 << sh);
      if (m > 255) m = 255;
      res[j*8 +: 8] = m[7:0];
    end
    return res;
  endfunction

  // Monitor: one line per presented transaction on a mismatch.
  always @(negedge clock) begin
    exp_t ea;
    exp_t eb;
    if (!reset) begin
      if (valid_a || blank_a) begin
        if (q_a.size() == 0) begin
          total++;
          bad++;
          $display("FAIL a_unexpected: valid=%0b blank=%0b dout=%0h want no output (cycle %0d)",
                   valid_a, blank_a, dout_a, cyc);
        end else begin
          ea = q_a.pop_front();
          check("a_valid", 64'(valid_a), 64'(!ea.blank));
          check("a_blank", 64'(blank_a), 64'(ea.blank));
          check("a_dout",  64'(dout_a),  64'(ea.blank ? 32'h0 : ea.data));
          if (ea.at >= 0) check("a_latency", 64'(cyc), 64'(ea.at));
        end
      end
      if (valid_b || blank_b) begin
        if (q_b.size() == 0) begin
          total++;
          bad++;
          $display("FAIL b_unexpected: valid=%0b blank=%0b dout=%0h want no output (cycle %0d)",
                   valid_b, blank_b, dout_b, cyc);
        end else begin
          eb = q_b.pop_front();
          check("b_valid", 64'(valid_b), 64'(!eb.blank));
          check("b_blank", 64'(blank_b), 64'(eb.blank));
          check("b_dout",  64'(dout_b),  64'(eb.blank ? 32'h0 : eb.data));
          if (eb.at >= 0) check("b_latency", 64'(cyc), 64'(eb.at));
        end
      end
    end
  end

  // One clock of stimulus; returns 1 time unit after the sampling edge.
  task automatic step(input logic [4:0] v, input logic [4:0] b, input logic [39:0] d);
    validin     = v;
    blanking_in = b;
    din         = d;
    @(posedge clock);
    #1;
    validin     = '0;
    blanking_in = '0;
    din         = '0;
  endtask

  // Aligned push of all scales with hand-computed expectations.
  task automatic push_aligned(input logic [39:0] d, input logic [4:0] b,
                              input logic [31:0] want_a, input logic [31:0] want_b,
                              input bit want_blank);
    exp_t e;
    e.blank = want_blank;
    e.at    = cyc + 2;
    e.data  = want_a;
    q_a.push_back(e);
    e.data  = want_b;
    q_b.push_back(e);
    step(5'h1f, b, d);
  endtask

  // Queue expectations computed by the reference model (aligned set g).
  task automatic expect_model(input logic [39:0] g, input bit want_blank);
    exp_t e;
    e.blank = want_blank;
    e.at    = -1;
    e.data  = ref_dog(g, 1'b0, 0);
    q_a.push_back(e);
    e.data  = ref_dog(g, 1'b1, 2);
    q_b.push_back(e);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200 && (q_a.size() != 0 || q_b.size() != 0); i++) begin
      @(posedge clock);
      #1;
    end
    check("drain_a", 64'(q_a.size()), 64'd0);
    check("drain_b", 64'(q_b.size()), 64'd0);
  endtask

  // Directed vectors: din packed {g4,g3,g2,g1,g0}
  logic [39:0] vec_g [5];
  logic [31:0] vec_a [5];
  logic [31:0] vec_b [5];

  initial begin
    logic [39:0] sdat [10];
    logic        sblk [10];
    logic [39:0] d;
    logic [39:0] g;
    logic [4:0]  v;
    logic [4:0]  b;
    logic [7:0]  p [15];
    int          idx;

    vec_g[0] = 40'h78_64_96_96_C8;  vec_a[0] = 32'h00_32_00_32;  vec_b[0] = 32'h50_C8_00_C8;
    vec_g[1] = 40'h0A_FA_28_64_C8;  vec_a[1] = 32'hF0_00_3C_64;  vec_b[1] = 32'hFF_FF_F0_FF;
    vec_g[2] = 40'h00_FF_00_FF_00;  vec_a[2] = 32'hFF_00_FF_00;  vec_b[2] = 32'hFF_FF_FF_FF;
    vec_g[3] = 40'h07_07_07_07_07;  vec_a[3] = 32'h00_00_00_00;  vec_b[3] = 32'h00_00_00_00;
    vec_g[4] = 40'h00_04_07_09_0A;  vec_a[4] = 32'h04_03_02_01;  vec_b[4] = 32'h10_0C_08_04;

    reset = 1'b1; clear_err = 1'b0; validin = '0; blanking_in = '0; din = '0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_outs_a", 64'({dout_a, valid_a, blank_a, ovf_a, mis_a}), 64'd0);
    check("rst_outs_b", 64'({dout_b, valid_b, blank_b, ovf_b, mis_b}), 64'd0);
    reset = 1'b0;
    step('0, '0, '0);

    // Aligned directed vectors, back to back: latency 2 and one word per cycle.
    for (int r = 0; r < 3; r++) push_aligned(vec_g[0], 5'b0, vec_a[0], vec_b[0], 1'b0);
    for (int i = 1; i < 5; i++) push_aligned(vec_g[i], 5'b0, vec_a[i], vec_b[i], 1'b0);
    wait_drain();
    check("flags_after_aligned_a", 64'({ovf_a, mis_a}), 64'd0);

    // Skewed arrival: scale k delayed 2*k cycles; sample 3 blanked on all scales.
    for (int i = 0; i < 10; i++) begin
      for (int k = 0; k < NS; k++) sdat[i][k*8 +: 8] = 8'((i * 37 + k * 53 + 11) % 256);
      sblk[i] = (i == 3);
      expect_model(sdat[i], sblk[i]);
    end
    for (int c = 0; c < 10 + 2 * (NS - 1); c++) begin
      v = '0; b = '0; d = '0;
      for (int k = 0; k < NS; k++) begin
        idx = c - 2 * k;
        if (idx >= 0 && idx < 10) begin
          v[k] = 1'b1;
          b[k] = sblk[idx];
          d[k*8 +: 8] = sdat[idx][k*8 +: 8];
        end
      end
      step(v, b, d);
    end
    wait_drain();
    check("skew_misalign_a", 64'(mis_a), 64'd0);
    check("skew_misalign_b", 64'(mis_b), 64'd0);

    // Blanking tag on scale 2 only: blank output and misalign set.
    push_aligned(vec_g[0], 5'b00100, 32'h0, 32'h0, 1'b1);
    step('0, '0, '0);
    check("misalign_set_a", 64'(mis_a), 64'd1);
    check("misalign_set_b", 64'(mis_b), 64'd1);
    clear_err = 1'b1;
    step('0, '0, '0);
    clear_err = 1'b0;
    check("misalign_clr_a", 64'(mis_a), 64'd0);

    // Set and clear in the same cycle: set wins.
    push_aligned(vec_g[0], 5'b00100, 32'h0, 32'h0, 1'b1);
    clear_err = 1'b1;
    step('0, '0, '0);
    clear_err = 1'b0;
    check("misalign_set_wins_a", 64'(mis_a), 64'd1);
    clear_err = 1'b1;
    step('0, '0, '0);
    clear_err = 1'b0;
    check("misalign_clr2_a", 64'(mis_a), 64'd0);
    wait_drain();

    // Fill scale 0 to 15, then aligned pushes: scale 0 becomes full and keeps
    // accepting because every following cycle also pops.
    for (int i = 0; i < 15; i++) begin
      p[i] = 8'(i * 10 + 5);
      step(5'b00001, '0, {32'h0, p[i]});
    end
    for (int i = 0; i < 6; i++) begin
      for (int k = 1; k < NS; k++) d[k*8 +: 8] = 8'(i * 29 + k * 41);
      d[7:0] = 8'(i + 200);
      g = {d[39:8], p[i]};
      expect_model(g, 1'b0);
      step(5'h1f, '0, d);
    end
    wait_drain();
    check("full_with_pop_ovf_a", 64'(ovf_a), 64'd0);

    // Scale 0 now holds 15: one more fills it, the next is dropped.
    step(5'b00001, '0, 40'h11);
    check("full_no_ovf_a", 64'(ovf_a), 64'd0);
    step(5'b00001, '0, 40'h22);
    check("ovf_set_a", 64'(ovf_a), 64'b00001);
    check("ovf_set_b", 64'(ovf_b), 64'b00001);
    clear_err = 1'b1;
    step('0, '0, '0);
    clear_err = 1'b0;
    check("ovf_clr_a", 64'(ovf_a), 64'd0);
    step(5'b00001, '0, 40'h33);
    check("ovf_reset_a", 64'(ovf_a), 64'b00001);

    // Reset with data buffered: outputs clear, FIFOs flush.
    reset = 1'b1;
    step('0, '0, '0);
    check("midrst_outs_a", 64'({dout_a, valid_a, blank_a, ovf_a, mis_a}), 64'd0);
    check("midrst_outs_b", 64'({dout_b, valid_b, blank_b, ovf_b, mis_b}), 64'd0);
    reset = 1'b0;
    push_aligned(vec_g[4], 5'b0, vec_a[4], vec_b[4], 1'b0);
    push_aligned(vec_g[1], 5'b0, vec_a[1], vec_b[1], 1'b0);
    wait_drain();
    check("final_flags_a", 64'({ovf_a, mis_a}), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish (cycle %0d)", cyc);
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
